// File: rtl/ac_hysteresis_controller_if.sv
// Sensor/setpoint inputs and drive/status outputs of the AC hysteresis controller.
// The controller uses the slave modport; whatever drives power and temperatures uses master.
interface ac_hysteresis_controller_if #(
    parameter int TEMP_W = 8
);
    logic              power;
    logic [TEMP_W-1:0] temp_act;
    logic [TEMP_W-1:0] temp_set;
    logic [1:0]        action;
    logic [2:0]        state_display;
    logic              lock;
    logic              fault;

    modport master (
        output power, temp_act, temp_set,
        input  action, state_display, lock, fault
    );

    modport slave (
        input  power, temp_act, temp_set,
        output action, state_display, lock, fault
    );
endinterface

// File: rtl/ac_hysteresis_controller.sv
// AC controller FSM with deadband compare, minimum-run and rest lockout timing.
// Optional run-time fault detection is enabled by defining ACC_FAULT_DETECT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_OFF   | unit powered down, no drive
// S_IDLE  | powered, waiting for temperature outside band and tmr==0
// S_COOL  | cooler driven; held at least MIN_RUN_CYC cycles
// S_HEAT  | heater driven; held at least MIN_RUN_CYC cycles
// S_FAULT | run exceeded MAX_RUN_CYC; held until power drops or reset
module ac_hysteresis_controller #(
    parameter int TEMP_W      = 8,
    parameter int DEADBAND    = 2,
    parameter int MIN_RUN_CYC = 4,
    parameter int REST_CYC    = 3,
    parameter int MAX_RUN_CYC = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    ac_hysteresis_controller_if.slave    bus
);
    localparam int TMR_MAX = (MIN_RUN_CYC > REST_CYC) ? MIN_RUN_CYC : REST_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]  TMR_RUN  = TMR_W'(MIN_RUN_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_REST = TMR_W'(REST_CYC - 1);
    localparam logic [TEMP_W:0]   DB_X     = (TEMP_W + 1)'(DEADBAND);

    if (MIN_RUN_CYC < 1 || REST_CYC < 1 || DEADBAND < 0 || MAX_RUN_CYC <= MIN_RUN_CYC)
    begin : g_bad_param
        $error("ac_hysteresis_controller: illegal timing parameters");
    end

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_IDLE  = 3'd1,
        S_COOL  = 3'd2,
        S_HEAT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;

    logic [TEMP_W:0] act_x, set_x;
    logic            hot, cold, run_now, run_nxt;

    // One extra bit so set+DEADBAND and act+DEADBAND never wrap.
    assign act_x = {1'b0, bus.temp_act};
    assign set_x = {1'b0, bus.temp_set};
    assign hot   = act_x > (set_x + DB_X);
    assign cold  = (act_x + DB_X) < set_x;

    assign run_now = (state == S_COOL) || (state == S_HEAT);
    assign run_nxt = (state_nxt == S_COOL) || (state_nxt == S_HEAT);

`ifdef ACC_FAULT_DETECT_EN
    localparam int RUN_W = $clog2(MAX_RUN_CYC + 1);

    logic [RUN_W-1:0] run_cnt, run_cnt_nxt, run_inc;
    logic             run_limit;

    assign run_inc   = run_cnt + 1'b1;
    assign run_limit = (run_inc == RUN_W'(MAX_RUN_CYC));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) run_cnt <= '0;
        else       run_cnt <= run_cnt_nxt;
    end

    always_comb begin
        run_cnt_nxt = run_cnt;
        if (run_nxt && !run_now)  run_cnt_nxt = '0;
        else if (run_nxt)         run_cnt_nxt = run_inc;
    end
`else
    logic run_limit;
    assign run_limit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_OFF;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = (tmr != '0) ? tmr - 1'b1 : tmr;

        if (!bus.power) begin
            state_nxt = S_OFF;
        end else begin
            unique case (state)
                S_OFF:   state_nxt = S_IDLE;
                S_IDLE: begin
                    if (tmr == '0 && hot)       state_nxt = S_COOL;
                    else if (tmr == '0 && cold) state_nxt = S_HEAT;
                end
                // Runs continue to the setpoint itself, not the band edge.
                S_COOL: begin
                    if (tmr == '0 && act_x <= set_x) state_nxt = S_IDLE;
                    else if (run_limit)              state_nxt = S_FAULT;
                end
                S_HEAT: begin
                    if (tmr == '0 && act_x >= set_x) state_nxt = S_IDLE;
                    else if (run_limit)              state_nxt = S_FAULT;
                end
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_OFF;
            endcase
        end

        // Run entry/exit loads override the plain decrement.
        if (run_nxt && !run_now)      tmr_nxt = TMR_RUN;
        else if (run_now && !run_nxt) tmr_nxt = TMR_REST;
    end

    always_comb begin
        bus.action = 2'b00;
        if (state == S_COOL)      bus.action = 2'b10;
        else if (state == S_HEAT) bus.action = 2'b01;
    end

    assign bus.state_display = state;
    assign bus.lock          = (tmr != '0);
`ifdef ACC_FAULT_DETECT_EN
    assign bus.fault         = (state == S_FAULT);
`else
    assign bus.fault         = 1'b0;
`endif
endmodule

// File: tb/tb_ac_hysteresis_controller.sv
// Directed self-checking bench for ac_hysteresis_controller (default parameters).
// The fault-detection section follows ACC_FAULT_DETECT_EN as the DUT does.
module tb_ac_hysteresis_controller;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    ac_hysteresis_controller_if #(.TEMP_W(8)) bus ();

    ac_hysteresis_controller #(
        .TEMP_W(8), .DEADBAND(2), .MIN_RUN_CYC(4), .REST_CYC(3), .MAX_RUN_CYC(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [1:0] act,
                           input logic lk, input logic flt);
        chk({tag, ".state"},  8'(bus.state_display), 8'(st));
        chk({tag, ".action"}, 8'(bus.action),        8'(act));
        chk({tag, ".lock"},   8'(bus.lock),          8'(lk));
        chk({tag, ".fault"},  8'(bus.fault),         8'(flt));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset        = 1'b1;
        bus.power    = 1'b1;
        bus.temp_set = 8'd20;
        bus.temp_act = 8'd20;
        #12;
        chk_all("reset", 3'd0, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;

        tick(); chk_all("off_to_idle", 3'd1, 2'b00, 1'b0, 1'b0);
        bus.temp_act = 8'd22;
        tick(); chk_all("in_band_22", 3'd1, 2'b00, 1'b0, 1'b0);

        // Cool run: enter with act=23, drop to setpoint at once; min run holds 4 cycles.
        bus.temp_act = 8'd23;
        tick(); chk_all("cool_enter", 3'd2, 2'b10, 1'b1, 1'b0);
        bus.temp_act = 8'd20;
        tick(); chk_all("cool_c2", 3'd2, 2'b10, 1'b1, 1'b0);
        tick(); chk_all("cool_c3", 3'd2, 2'b10, 1'b1, 1'b0);
        tick(); chk_all("cool_c4", 3'd2, 2'b10, 1'b0, 1'b0);
        tick(); chk_all("cool_exit", 3'd1, 2'b00, 1'b1, 1'b0);

        // Cold right after a cool run: rest lockout, then HEAT.
        bus.temp_act = 8'd17;
        tick(); chk_all("rest_r2", 3'd1, 2'b00, 1'b1, 1'b0);
        tick(); chk_all("rest_r3", 3'd1, 2'b00, 1'b0, 1'b0);
        tick(); chk_all("heat_enter", 3'd3, 2'b01, 1'b1, 1'b0);

        // Power drop overrides lock.
        bus.power = 1'b0;
        tick(); chk_all("heat_pwr_off", 3'd0, 2'b00, 1'b1, 1'b0);
        bus.power = 1'b1;
        tick(); chk_all("pwr_on_locked", 3'd1, 2'b00, 1'b1, 1'b0);
        tick(); chk_all("pwr_on_unlock", 3'd1, 2'b00, 1'b0, 1'b0);
        tick(); chk_all("heat_again", 3'd3, 2'b01, 1'b1, 1'b0);

        // Heat run to setpoint.
        bus.temp_act = 8'd20;
        tick(); tick(); tick();
        chk_all("heat_h4", 3'd3, 2'b01, 1'b0, 1'b0);
        tick(); chk_all("heat_exit", 3'd1, 2'b00, 1'b1, 1'b0);

        // Hysteresis: COOL continues inside the band, setpoint change ends it.
        bus.temp_act = 8'd23;
        tick(); tick();
        chk_all("rest_done", 3'd1, 2'b00, 1'b0, 1'b0);
        tick(); chk_all("cool2_enter", 3'd2, 2'b10, 1'b1, 1'b0);
        bus.temp_act = 8'd21;
        tick(); tick(); tick(); tick(); tick();
        chk_all("cool2_in_band", 3'd2, 2'b10, 1'b0, 1'b0);
        bus.temp_set = 8'd21;
        tick(); chk_all("cool2_set_chg", 3'd1, 2'b00, 1'b1, 1'b0);

        // Async reset mid-COOL.
        bus.temp_set = 8'd20;
        bus.temp_act = 8'd23;
        tick(); tick(); tick();
        chk_all("cool3_enter", 3'd2, 2'b10, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 chk_all("async_reset", 3'd0, 2'b00, 1'b0, 1'b0);
        #1 reset = 1'b0;

        // Long cool with unreachable setpoint.
        bus.temp_act = 8'd30;
        tick(); chk_all("long_idle", 3'd1, 2'b00, 1'b0, 1'b0);
        tick(); chk_all("long_cool", 3'd2, 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) tick();
        chk_all("long_c32", 3'd2, 2'b10, 1'b0, 1'b0);
        tick();
`ifdef ACC_FAULT_DETECT_EN
        chk_all("fault_enter", 3'd4, 2'b00, 1'b1, 1'b1);
        tick(); chk_all("fault_hold", 3'd4, 2'b00, 1'b1, 1'b1);
        bus.power = 1'b0;
        tick(); chk_all("fault_pwr_off", 3'd0, 2'b00, 1'b0, 1'b0);
`else
        chk_all("no_fault_c33", 3'd2, 2'b10, 1'b0, 1'b0);
        bus.power = 1'b0;
        tick(); chk_all("cool_pwr_off", 3'd0, 2'b00, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
